wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the writeback data width.
REQ-002 Parameter N_REQ, default 3, SHALL set the number of writeback requesters (ALU=0, LSU=1, VEC=2).
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 Port clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port req_valid_i  input  N_REQ  SHALL be the per-requester writeback-valid bits.
REQ-007 Port req_rd_addr_i  input  N_REQ x 5  SHALL be the per-requester destination register.
REQ-008 Port req_data_i  input  N_REQ x DATA_WIDTH  SHALL be the per-requester write data.
REQ-009 Port req_ready_o  output  N_REQ  SHALL be the per-requester accept bits, one-hot or zero.
REQ-010 Port reg_write_o  output  1  SHALL drive the register file write enable.
REQ-011 Port rd_addr_o  output  5  SHALL drive the register file destination address.
REQ-012 Port rd_data_o  output  DATA_WIDTH  SHALL drive the register file write data.
REQ-013 Port grant_idx_o  output  $clog2(N_REQ)  SHALL carry the index of the requester whose write is on the outputs.
REQ-014 Port write_count_o  output  32  SHALL count the register writes issued.

Function
REQ-015 Each cycle, the block SHALL grant at most one valid requester by round-robin, searching upward from pointer ptr with wrap at N_REQ.
REQ-016 req_ready_o[i] SHALL be combinational from req_valid_i and ptr only, and SHALL be 1 only for the granted requester.
REQ-017 A transfer SHALL occur when valid and ready are both 1; the block SHALL accept one transfer every cycle whenever any valid is high.
REQ-018 A requester SHALL hold valid, address and data stable until accepted; the block SHALL NOT depend on valid dropping before ready.
REQ-019 On a grant to i, ptr SHALL become (i+1) mod N_REQ next cycle; with no grant, ptr SHALL hold.
REQ-020 The latency from accept to write SHALL be exactly 1 cycle: the registered rd_addr_o, rd_data_o and grant_idx_o SHALL appear in the next cycle.
REQ-021 A write to rd=0 SHALL be accepted and SHALL advance ptr, but the following cycle SHALL have reg_write_o=0 and write_count_o unchanged.
REQ-022 Whenever reg_write_o=0 in a cycle, rd_addr_o, rd_data_o and grant_idx_o SHALL be 0.
REQ-023 write_count_o SHALL increment by 1 on each cycle with reg_write_o=1, wrapping from 0xFFFFFFFF to 0.
REQ-024 When requests are simultaneous, ungranted requesters SHALL wait with ready=0; each requester SHALL wait at most N_REQ-1 grants before being granted.
REQ-025 When requests target the same rd, they SHALL be serialized in grant order, so that the last write issued is the value retained.

Reset
REQ-026 While rst=1: req_ready_o=0, reg_write_o=0, rd_addr_o=0, rd_data_o=0, grant_idx_o=0, write_count_o=0, ptr=0.
REQ-027 A request accepted in the cycle before rst is asserted SHALL be discarded; no write SHALL issue during or after that reset.
REQ-028 In the first cycle after rst deasserts, the block SHALL arbitrate normally with ptr=0.

Structure
REQ-029 Package wb_arb_pkg SHALL hold the N_REQ default, the requester-index typedef and the requester enum (REQ_ALU, REQ_LSU, REQ_VEC).
REQ-030 A combinational sub-module rr_pick SHALL implement the masked round-robin priority pick (inputs valid and ptr; outputs one-hot grant, index and any-grant).
REQ-031 The output register, ptr and counter SHALL live in wb_arbiter; no other state SHALL exist.

Verification
REQ-032 Scenario: after reset, all three valid with rd=5/6/7 and data 0xA/0xB/0xC held; required response: writes issue x5, x6, x7 on consecutive cycles; grant_idx 0,1,2; write_count_o ends at 3.
REQ-033 Scenario: LSU alone valid for 4 cycles with data 0x11..0x14 to rd=9; required response: ready every cycle and 4 back-to-back writes, each 1 cycle after accept.
REQ-034 Scenario: ALU valid with rd=0 and data 0xDEAD; required response: ready=1, next cycle reg_write_o=0, count unchanged, ptr advances to 1.
REQ-035 Scenario: ALU and VEC both write rd=3 (0x1 and 0x2) with ptr=2; required response: VEC first, then ALU, so x3 finally holds 0x1.
REQ-036 Scenario: rst asserted the cycle after a request is accepted; required response: reg_write_o stays 0 and all outputs and the count read 0.
REQ-037 Scenario: preload write_count_o at 0xFFFFFFFF (force), then one write; required response: write_count_o reads 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared requester definitions for the writeback arbiter
package wb_arb_pkg;

    localparam int N_REQ_DEF = 3;
    localparam int REQ_IDX_W = $clog2(N_REQ_DEF);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic [REQ_IDX_W-1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_VEC = 2'd2
    } req_id_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk N positions upward from ptr with wrap; the first valid one wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter driving one register file write port
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = N_REQ_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*5-1:0]          req_rd_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        reg_write_o,
    output logic [4:0]                  rd_addr_o,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic [$clog2(N_REQ)-1:0]    grant_idx_o,
    output logic [31:0]                 write_count_o
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]         ptr;
    logic [N_REQ-1:0]      pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_q;
    logic [4:0]            addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IW-1:0]         idx_q;
    logic [31:0]           count_q;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_addr = req_rd_addr_i[int'(pick_idx)*5 +: 5];
    assign sel_data = req_data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Writes to x0 still consume a grant but leave the output register idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            if (pick_any) begin
                ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            wr_q    <= pick_any && (sel_addr != 5'd0);
            addr_q  <= (pick_any && (sel_addr != 5'd0)) ? sel_addr : '0;
            data_q  <= (pick_any && (sel_addr != 5'd0)) ? sel_data : '0;
            idx_q   <= (pick_any && (sel_addr != 5'd0)) ? pick_idx : '0;
            if (wr_q) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Reset masks the outputs at once so a write accepted just before reset never issues.
    assign req_ready_o   = rst ? '0 : pick_grant;
    assign reg_write_o   = wr_q & ~rst;
    assign rd_addr_o     = rst ? '0 : addr_q;
    assign rd_data_o     = rst ? '0 : data_q;
    assign grant_idx_o   = rst ? '0 : idx_q;
    assign write_count_o = rst ? '0 : count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a behavioural model
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v [N];
    logic [4:0]    a [N];
    logic [DW-1:0] d [N];

    logic [N-1:0]    req_valid;
    logic [N*5-1:0]  req_rd_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [DW-1:0]   rd_data;
    logic [1:0]      grant_idx;
    logic [31:0]     write_count;

    assign req_valid   = {v[2], v[1], v[0]};
    assign req_rd_addr = {a[2], a[1], a[0]};
    assign req_data    = {d[2], d[1], d[0]};

    wb_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_rd_addr_i (req_rd_addr),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .reg_write_o   (reg_write),
        .rd_addr_o     (rd_addr),
        .rd_data_o     (rd_data),
        .grant_idx_o   (grant_idx),
        .write_count_o (write_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pointer, pending write shown next cycle, counter, register file image.
    int          m_ptr   = 0;
    logic        m_wr    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    int          m_idx   = 0;
    logic [31:0] m_count = '0;
    int          waits [N] = '{0, 0, 0};
    logic [31:0] rf [32];
    logic        acc_v = 1'b0;
    int          acc_i = 0;

    always @(negedge clk) begin
        logic gv;
        int   gi;
        logic [N-1:0] exp_ready;
        gv = 1'b0;
        gi = 0;
        for (int k = 0; k < N; k++) begin
            if (!gv && v[(m_ptr + k) % N]) begin
                gv = 1'b1;
                gi = (m_ptr + k) % N;
            end
        end
        exp_ready = (rst || !gv) ? '0 : N'(1 << gi);
        chk("ready", 32'(req_ready), 32'(exp_ready));
        chk("reg_write", 32'(reg_write), 32'(!rst && m_wr));
        chk("rd_addr", 32'(rd_addr), (rst || !m_wr) ? 32'd0 : 32'(m_addr));
        chk("rd_data", rd_data, (rst || !m_wr) ? 32'd0 : m_data);
        chk("grant_idx", 32'(grant_idx), (rst || !m_wr) ? 32'd0 : 32'(m_idx));
        chk("write_count", write_count, rst ? 32'd0 : m_count);

        for (int i = 0; i < N; i++) begin
            if (rst) begin
                waits[i] = 0;
            end else if (gv && i == gi) begin
                chk("wait_bound", 32'(waits[i] <= N - 1), 32'd1);
                waits[i] = 0;
            end else if (gv && v[i]) begin
                waits[i]++;
            end
        end

        if (reg_write) rf[rd_addr] = rd_data;
        acc_v = !rst && gv;
        acc_i = gi;

        if (rst) begin
            m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_idx = 0; m_count = '0;
        end else begin
            if (m_wr) m_count = m_count + 32'd1;
            m_wr   = gv && (a[gi] != 5'd0);
            m_addr = a[gi];
            m_data = d[gi];
            m_idx  = gi;
            if (gv) m_ptr = (gi + 1) % N;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_v) v[acc_i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        for (int i = 0; i < 32; i++) rf[i] = '0;

        step(); step(); step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_write", 32'(reg_write), 32'd0);
        chk("rst_count", write_count, 32'd0);
        chk("rst_ptr", 32'(dut.ptr), 32'd0);

        // All three requesters at once: served ALU, LSU, VEC in order.
        rst = 1'b0;
        v[0] = 1; a[0] = 5; d[0] = 32'hA;
        v[1] = 1; a[1] = 6; d[1] = 32'hB;
        v[2] = 1; a[2] = 7; d[2] = 32'hC;
        #1 chk("s32_ready0", 32'(req_ready), 32'b001);
        step();
        chk("s32_addr0", 32'(rd_addr), 32'd5);
        chk("s32_idx0", 32'(grant_idx), 32'd0);
        step();
        chk("s32_addr1", 32'(rd_addr), 32'd6);
        chk("s32_idx1", 32'(grant_idx), 32'd1);
        step();
        chk("s32_addr2", 32'(rd_addr), 32'd7);
        chk("s32_data2", rd_data, 32'hC);
        chk("s32_idx2", 32'(grant_idx), 32'd2);
        step();
        chk("s32_count", write_count, 32'd3);

        // x0 write: accepted, pointer moves, nothing issued.
        v[0] = 1; a[0] = 0; d[0] = 32'hDEAD;
        #1 chk("s34_ready", 32'(req_ready), 32'b001);
        step();
        chk("s34_write", 32'(reg_write), 32'd0);
        chk("s34_count", write_count, 32'd3);
        chk("s34_ptr", 32'(dut.ptr), 32'd1);

        // LSU streaming back-to-back.
        for (int k = 0; k < 4; k++) begin
            v[1] = 1; a[1] = 9; d[1] = 32'h11 + k;
            #1 chk("s33_ready", 32'(req_ready), 32'b010);
            step();
            chk("s33_write", 32'(reg_write), 32'd1);
            chk("s33_data", rd_data, 32'h11 + k);
        end
        step();

        // Same destination, pointer at VEC: VEC first, ALU value survives.
        v[0] = 1; a[0] = 3; d[0] = 32'h1;
        v[2] = 1; a[2] = 3; d[2] = 32'h2;
        #1 chk("s35_ready", 32'(req_ready), 32'b100);
        step();
        chk("s35_first", rd_data, 32'h2);
        step();
        chk("s35_second", rd_data, 32'h1);
        step();
        chk("s35_x3", rf[3], 32'h1);

        // Reset right after an accept discards that write.
        v[0] = 1; a[0] = 4; d[0] = 32'h44;
        step();
        rst = 1'b1;
        #1;
        chk("s36_write", 32'(reg_write), 32'd0);
        chk("s36_addr", 32'(rd_addr), 32'd0);
        chk("s36_data", rd_data, 32'd0);
        chk("s36_count", write_count, 32'd0);
        step();
        chk("s36_write2", 32'(reg_write), 32'd0);
        rst = 1'b0;
        step();
        chk("s36_write3", 32'(reg_write), 32'd0);
        chk("s36_count2", write_count, 32'd0);

        // Counter wrap.
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        v[0] = 1; a[0] = 8; d[0] = 32'h88;
        step();
        chk("s37_write", 32'(reg_write), 32'd1);
        chk("s37_pre", write_count, 32'hFFFF_FFFF);
        step();
        chk("s37_wrap", write_count, 32'd0);

        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            end
            step();
        end
        rst = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
